// File: rtl/counter_forward_mod.sv
// Up-counter with parallel load, programmable wrap limit and a sticky overflow flag.
// A count step wraps to zero at the limit or at all ones, so the counter never stalls.
module counter_forward_mod #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  action_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic [WORD_WIDTH-1:0] limit_i,
    input  logic                  limit_we_i,
    input  logic                  ovf_clr_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic [WORD_WIDTH-1:0] limit_o,
    output logic                  will_overflow_o,
    output logic                  overflow_o
);

    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [WORD_WIDTH-1:0] limit_q, limit_d;
    logic                  overflow_q, overflow_d;
    logic                  wrap;
    logic                  count_wrap;

    // The all-ones term lets values loaded above the limit still roll over.
    always_comb begin
        wrap       = (data_q == limit_q) | (&data_q);
        count_wrap = en_i & ~action_i & wrap;
    end

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            if (action_i) begin
                data_d = data_i;
            end else if (wrap) begin
                data_d = '0;
            end else begin
                data_d = data_q + ONE;
            end
        end
    end

    // The new limit only matters from the next cycle; this cycle compares against limit_q.
    always_comb begin
        limit_d = limit_q;
        if (limit_we_i) begin
            limit_d = limit_i;
        end
    end

    // A wrap on the same edge as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (count_wrap) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            limit_q    <= '1;
            overflow_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            limit_q    <= limit_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        data_o          = data_q;
        limit_o         = limit_q;
        will_overflow_o = wrap;
        overflow_o      = overflow_q;
    end

endmodule

// File: tb/tb_counter_forward_mod.sv
// Scoreboard bench for counter_forward_mod: a driver feeds a modulo-arithmetic model
// and queues expected outputs; a monitor pops and compares after every rising edge.
module tb_counter_forward_mod;

    localparam int W   = 8;
    localparam int MOD = 1 << W;
    localparam int EW  = 2 * W + 2;

    logic         clk;
    logic         rst;
    logic         en;
    logic         action;
    logic [W-1:0] data_in;
    logic [W-1:0] limit_in;
    logic         limit_we;
    logic         ovf_clr;
    logic [W-1:0] data_out;
    logic [W-1:0] limit_out;
    logic         will_ovf;
    logic         ovf;

    logic [EW-1:0] exp_q[$];
    int            checks;
    int            failures;

    // Reference state held as plain integers.
    int m_cnt;
    int m_lim;
    int m_ovf;

    counter_forward_mod #(.WORD_WIDTH(W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .action_i        (action),
        .data_i          (data_in),
        .limit_i         (limit_in),
        .limit_we_i      (limit_we),
        .ovf_clr_i       (ovf_clr),
        .data_o          (data_out),
        .limit_o         (limit_out),
        .will_overflow_o (will_ovf),
        .overflow_o      (ovf)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: apply one cycle of inputs at the falling edge and queue the expected result
    task automatic step(input logic r, input logic e, input logic a, input int d,
                        input int l, input logic lwe, input logic clr);
        int  next_cnt;
        bit  wraps;
        logic [W-1:0] c8;
        logic [W-1:0] l8;
        bit  will;
        @(negedge clk);
        rst      = r;
        en       = e;
        action   = a;
        data_in  = W'(d);
        limit_in = W'(l);
        limit_we = lwe;
        ovf_clr  = clr;
        if (r) begin
            m_cnt = 0;
            m_lim = MOD - 1;
            m_ovf = 0;
        end else begin
            wraps    = (m_cnt == m_lim) || (m_cnt == MOD - 1);
            next_cnt = m_cnt;
            if (e && a)       next_cnt = d % MOD;
            else if (e)       next_cnt = wraps ? 0 : (m_cnt + 1) % MOD;
            if (e && !a && wraps) m_ovf = 1;
            else if (clr)         m_ovf = 0;
            if (lwe) m_lim = l % MOD;
            m_cnt = next_cnt;
        end
        will = (m_cnt == m_lim) || (m_cnt == MOD - 1);
        c8 = W'(m_cnt);
        l8 = W'(m_lim);
        exp_q.push_back({c8, l8, m_ovf[0], will});
    endtask

    task automatic count_n(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] exp;
        logic [EW-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {data_out, limit_out, ovf, will_ovf};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL outputs t=%0t data=%02h/%02h limit=%02h/%02h ovf=%b/%b will=%b/%b (actual/required)",
                             $time, act[EW-1 -: W], exp[EW-1 -: W], act[W+1 +: W], exp[W+1 +: W],
                             act[1], exp[1], act[0], exp[0]);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_cnt = 0; m_lim = MOD - 1; m_ovf = 0;
        rst = 1'b1; en = 1'b0; action = 1'b0; data_in = '0;
        limit_in = '0; limit_we = 1'b0; ovf_clr = 1'b0;

        // reset then full 256-step roll-over at the default limit
        step(1, 0, 0, 0, 0, 0, 0);
        count_n(256);

        // clear flag, limit 5, count 7
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 5, 1, 0);
        count_n(7);

        // load above limit then count through 0xFF
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 'hFD, 0, 0, 0);
        count_n(3);

        // hold with action toggling
        for (int i = 0; i < 6; i++) step(0, 0, i[0], $urandom_range(0, MOD - 1), 0, 0, 0);

        // limit write coinciding with a count uses the old limit
        step(1, 0, 0, 0, 0, 0, 0);
        count_n(3);
        step(0, 1, 0, 0, 3, 1, 0);
        count_n(253);

        // set beats clear on a wrap step, then plain clear
        step(0, 1, 1, 3, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // reset overrides load, limit write and clear
        step(0, 1, 1, 'h42, 0, 0, 0);
        step(1, 1, 1, 'h99, 'h10, 1, 1);

        // limit 0 sticks at 0 with a wrap every step
        step(0, 0, 0, 0, 0, 1, 0);
        count_n(4);
        step(0, 0, 0, 0, 'hFF, 1, 1);

        // randomized traffic, limits biased small so wraps are frequent
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, MOD - 1),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, MOD - 1) : $urandom_range(0, 12),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
